// File: rtl/usb_ep_buf_arbiter.sv
// usb_ep_buf_arbiter
// Shares one byte-wide single-port endpoint buffer RAM between the USB SIE and
// the CPU pin interface. Each endpoint buffer is owned by exactly one side at a
// time; ownership moves only through cpu_arm (CPU -> SIE) and sie_done
// (SIE -> CPU). Every cycle at most one valid access reaches the RAM. The SIE
// has priority, but a CPU that has lost MAX_WAIT times in a row wins next.
// Read data comes back one cycle after the grant, tagged for the side that
// issued it.

module usb_ep_buf_arbiter #(
  parameter int N_EP     = 4,
  parameter int EP_BYTES = 8,
  parameter int EPW      = 2,
  parameter int OFFW     = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  // SIE access port
  input  logic              sie_req,
  input  logic              sie_we,
  input  logic [EPW-1:0]    sie_ep,
  input  logic [OFFW-1:0]   sie_off,
  input  logic [7:0]        sie_wdata,
  output logic              sie_gnt,
  output logic              sie_err,
  output logic              sie_rvalid,
  input  logic              sie_done,
  input  logic [EPW-1:0]    sie_done_ep,
  input  logic [OFFW:0]     sie_done_len,

  // CPU access port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [EPW-1:0]    cpu_ep,
  input  logic [OFFW-1:0]   cpu_off,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_err,
  output logic              cpu_rvalid,
  input  logic              cpu_arm,
  input  logic [EPW-1:0]    cpu_arm_ep,
  input  logic [OFFW:0]     cpu_arm_len,
  output logic              cpu_arm_err,

  // Status
  input  logic [EPW-1:0]    len_sel,
  output logic [OFFW:0]     len_out,
  output logic [N_EP-1:0]   ep_owner,

  // Shared read data and RAM port
  output logic [7:0]        rdata,
  output logic [EPW+OFFW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_en,
  input  logic [7:0]        mem_rdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0]  WAIT_LIMIT = WCW'(MAX_WAIT);
  localparam logic [OFFW:0]   LEN_MAX    = (OFFW+1)'(EP_BYTES);

  // Which side, if any, is owed read data on the next cycle.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SIE  = 2'd1,
    TAG_CPU  = 2'd2
  } rd_tag_e;

  logic [OFFW:0]   ep_len [N_EP];
  logic [WCW-1:0]  wait_cnt;
  logic [WCW-1:0]  wait_cnt_nxt;
  rd_tag_e         rd_tag;
  rd_tag_e         rd_tag_nxt;
  logic            arm_err_q;

  logic            sie_valid;
  logic            cpu_valid;
  logic            cpu_wins;

  // Byte counts larger than a buffer are clamped to the buffer size.
  function automatic logic [OFFW:0] clamp_len(input logic [OFFW:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  // Request validity from current ownership, and the arbitration decision.
  always_comb begin
    sie_valid = sie_req &&  ep_owner[sie_ep];
    cpu_valid = cpu_req && !ep_owner[cpu_ep];
    cpu_wins  = cpu_valid && (!sie_valid || (wait_cnt >= WAIT_LIMIT));
  end

  // Grants, error pulses and RAM port steering from the winner.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    sie_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    sie_err   = sie_req && !ep_owner[sie_ep];
    cpu_err   = cpu_req &&  ep_owner[cpu_ep];
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {sie_ep, sie_off};
    mem_wdata = sie_wdata;

    if (cpu_wins) begin
      cpu_gnt   = 1'b1;
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = {cpu_ep, cpu_off};
      mem_wdata = cpu_wdata;
    end else if (sie_valid) begin
      sie_gnt   = 1'b1;
      mem_en    = 1'b1;
      mem_we    = sie_we;
    end
  end

  // Next wait count and next read tag.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!cpu_req || cpu_gnt) begin
      wait_cnt_nxt = '0;
    end else if (cpu_valid && (wait_cnt < WAIT_LIMIT)) begin
      wait_cnt_nxt = wait_cnt + 1'b1;
    end

    rd_tag_nxt = TAG_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_tag_nxt = TAG_CPU;
    end else if (sie_gnt && !sie_we) begin
      rd_tag_nxt = TAG_SIE;
    end
  end

  // Arbitration state: fairness counter, read-return tag, arm error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      rd_tag    <= TAG_NONE;
      arm_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      wait_cnt  <= wait_cnt_nxt;
      rd_tag    <= rd_tag_nxt;
      arm_err_q <= cpu_arm && ep_owner[cpu_arm_ep];
    end
  end

  // Ownership and length table, updated by arm and done handshakes.
  // Arm needs a CPU-owned buffer and done a SIE-owned one, so the two can
  // never hit the same endpoint in one cycle and both apply independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ep_owner <= '0;
      // NOTE: the length table is a handful of flops, not a RAM macro, so it
      // is reset like any other register; software reads it right after reset.
      for (int i = 0; i < N_EP; i++) begin
        ep_len[i] <= '0;
      end
    end else begin
      if (cpu_arm && !ep_owner[cpu_arm_ep]) begin
        ep_owner[cpu_arm_ep] <= 1'b1;
        ep_len[cpu_arm_ep]   <= clamp_len(cpu_arm_len);
      end
      if (sie_done && ep_owner[sie_done_ep]) begin
        ep_owner[sie_done_ep] <= 1'b0;
        ep_len[sie_done_ep]   <= clamp_len(sie_done_len);
      end
    end
  end

  // Read return and status outputs.
  always_comb begin
    sie_rvalid  = (rd_tag == TAG_SIE);
    cpu_rvalid  = (rd_tag == TAG_CPU);
    rdata       = mem_rdata;
    cpu_arm_err = arm_err_q;
    len_out     = ep_len[len_sel];
  end

endmodule

// File: tb/tb_usb_ep_buf_arbiter.sv
// Directed testbench for usb_ep_buf_arbiter with a 1-cycle-latency RAM model.
// Inputs change 1 ns after the rising edge; outputs are checked before the
// next rising edge (combinational) or 1 ns after it (registered).

module tb_usb_ep_buf_arbiter;

  localparam int N_EP = 4, EP_BYTES = 8, EPW = 2, OFFW = 3, MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic sie_req, sie_we, sie_done;
  logic [EPW-1:0] sie_ep, sie_done_ep;
  logic [OFFW-1:0] sie_off;
  logic [7:0] sie_wdata;
  logic [OFFW:0] sie_done_len;
  logic sie_gnt, sie_err, sie_rvalid;
  logic cpu_req, cpu_we, cpu_arm;
  logic [EPW-1:0] cpu_ep, cpu_arm_ep;
  logic [OFFW-1:0] cpu_off;
  logic [7:0] cpu_wdata;
  logic [OFFW:0] cpu_arm_len;
  logic cpu_gnt, cpu_err, cpu_rvalid, cpu_arm_err;
  logic [EPW-1:0] len_sel;
  logic [OFFW:0] len_out;
  logic [N_EP-1:0] ep_owner;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [EPW+OFFW-1:0] mem_addr;
  logic mem_we, mem_en;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usb_ep_buf_arbiter #(
    .N_EP(N_EP), .EP_BYTES(EP_BYTES), .EPW(EPW), .OFFW(OFFW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sie_req(sie_req), .sie_we(sie_we), .sie_ep(sie_ep), .sie_off(sie_off),
    .sie_wdata(sie_wdata), .sie_gnt(sie_gnt), .sie_err(sie_err),
    .sie_rvalid(sie_rvalid), .sie_done(sie_done), .sie_done_ep(sie_done_ep),
    .sie_done_len(sie_done_len),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ep(cpu_ep), .cpu_off(cpu_off),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_err(cpu_err),
    .cpu_rvalid(cpu_rvalid), .cpu_arm(cpu_arm), .cpu_arm_ep(cpu_arm_ep),
    .cpu_arm_len(cpu_arm_len), .cpu_arm_err(cpu_arm_err),
    .len_sel(len_sel), .len_out(len_out), .ep_owner(ep_owner),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_en(mem_en), .mem_rdata(mem_rdata)
  );

  // Buffer RAM model: synchronous, read-before-write, 1-cycle read latency.
  logic [7:0] ram [N_EP*EP_BYTES];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_cpu;
    logic prev_cpu;

    rst_n = 1'b0;
    sie_req = 0; sie_we = 0; sie_ep = 0; sie_off = 0; sie_wdata = 0;
    sie_done = 0; sie_done_ep = 0; sie_done_len = 0;
    cpu_req = 0; cpu_we = 0; cpu_ep = 0; cpu_off = 0; cpu_wdata = 0;
    cpu_arm = 0; cpu_arm_ep = 0; cpu_arm_len = 0; len_sel = 0;
    step(); step();
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_owner", ep_owner, 4'b0000);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_sie_rvalid", sie_rvalid, 1'b0);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_arm_err", cpu_arm_err, 1'b0);
    check("rst_len0", len_out, 4'd0);

    // CPU write ep1 off3 = A5
    step();
    cpu_req = 1; cpu_we = 1; cpu_ep = 2'd1; cpu_off = 3'd3; cpu_wdata = 8'hA5;
    #1;
    check("cw_gnt", cpu_gnt, 1'b1);
    check("cw_sie_gnt", sie_gnt, 1'b0);
    check("cw_mem_en", mem_en, 1'b1);
    check("cw_mem_we", mem_we, 1'b1);
    check("cw_mem_addr", mem_addr, 5'h0B);
    check("cw_mem_wdata", mem_wdata, 8'hA5);
    step();

    // CPU read ep1 off3
    cpu_we = 0;
    #1;
    check("cr_gnt", cpu_gnt, 1'b1);
    check("cr_mem_we", mem_we, 1'b0);
    step();
    cpu_req = 0;
    check("cr_rvalid", cpu_rvalid, 1'b1);
    check("cr_rdata", rdata, 8'hA5);
    check("cr_sie_rvalid", sie_rvalid, 1'b0);
    step();
    check("cr_rvalid_off", cpu_rvalid, 1'b0);

    // SIE read of a CPU-owned buffer is rejected
    sie_req = 1; sie_we = 0; sie_ep = 2'd1; sie_off = 3'd3;
    #1;
    check("se_err", sie_err, 1'b1);
    check("se_gnt", sie_gnt, 1'b0);
    check("se_mem_en", mem_en, 1'b0);
    step();
    sie_req = 0;
    check("se_no_rvalid", sie_rvalid, 1'b0);

    // Arm ep2 with len 12 (clamped to 8)
    cpu_arm = 1; cpu_arm_ep = 2'd2; cpu_arm_len = 4'd12;
    step();
    cpu_arm = 0; len_sel = 2'd2;
    #1;
    check("arm_owner", ep_owner, 4'b0100);
    check("arm_len_clamp", len_out, 4'd8);
    check("arm_no_err", cpu_arm_err, 1'b0);
    cpu_req = 1; cpu_we = 1; cpu_ep = 2'd2; cpu_off = 3'd0;
    #1;
    check("cpu_own_err", cpu_err, 1'b1);
    check("cpu_own_gnt", cpu_gnt, 1'b0);
    check("cpu_own_mem_en", mem_en, 1'b0);
    step();
    cpu_req = 0;
    cpu_arm = 1; cpu_arm_ep = 2'd2; cpu_arm_len = 4'd3;
    step();
    cpu_arm = 0;
    check("rearm_err", cpu_arm_err, 1'b1);
    check("rearm_len_kept", len_out, 4'd8);
    check("rearm_owner", ep_owner, 4'b0100);
    step();
    check("rearm_err_pulse", cpu_arm_err, 1'b0);

    // Seed data: CPU writes ep0 off1 = 5A, SIE writes ep2 off4 = 3C (same cycle, SIE first)
    sie_req = 1; sie_we = 1; sie_ep = 2'd2; sie_off = 3'd4; sie_wdata = 8'h3C;
    cpu_req = 1; cpu_we = 1; cpu_ep = 2'd0; cpu_off = 3'd1; cpu_wdata = 8'h5A;
    #1;
    check("seed_sie_gnt", sie_gnt, 1'b1);
    check("seed_cpu_lose", cpu_gnt, 1'b0);
    check("seed_mem_addr", mem_addr, 5'h14);
    step();
    sie_req = 0;
    #1;
    check("seed_cpu_gnt", cpu_gnt, 1'b1);
    step();
    cpu_req = 0;
    step();

    // Contention: both read for 10 cycles; CPU wins on cycles 5 and 10
    sie_req = 1; sie_we = 0; sie_ep = 2'd2; sie_off = 3'd4;
    cpu_req = 1; cpu_we = 0; cpu_ep = 2'd0; cpu_off = 3'd1;
    prev_cpu = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      exp_cpu = (c == 5) || (c == 10);
      check($sformatf("arb_cpu_gnt_c%0d", c), cpu_gnt, exp_cpu);
      check($sformatf("arb_sie_gnt_c%0d", c), sie_gnt, !exp_cpu);
      if (c > 1) begin
        check($sformatf("arb_rvalid_c%0d", c), {sie_rvalid, cpu_rvalid}, {!prev_cpu, prev_cpu});
        check($sformatf("arb_rdata_c%0d", c), rdata, prev_cpu ? 8'h5A : 8'h3C);
      end
      prev_cpu = exp_cpu;
      step();
    end
    sie_req = 0; cpu_req = 0;
    check("arb_last_rvalid", {sie_rvalid, cpu_rvalid}, 2'b01);
    check("arb_last_rdata", rdata, 8'h5A);
    step();

    // Simultaneous done ep2 len5 and arm ep0 len3
    sie_done = 1; sie_done_ep = 2'd2; sie_done_len = 4'd5;
    cpu_arm = 1; cpu_arm_ep = 2'd0; cpu_arm_len = 4'd3;
    step();
    sie_done = 0; cpu_arm = 0;
    len_sel = 2'd2;
    #1;
    check("da_owner", ep_owner, 4'b0001);
    check("da_len2", len_out, 4'd5);
    len_sel = 2'd0;
    #1;
    check("da_len0", len_out, 4'd3);
    check("da_arm_err", cpu_arm_err, 1'b0);

    // Reset while a SIE read return is pending
    sie_req = 1; sie_we = 0; sie_ep = 2'd0; sie_off = 3'd0;
    #1;
    check("rr_sie_gnt", sie_gnt, 1'b1);
    @(posedge clk);
    sie_req = 0;
    rst_n = 1'b0;
    #1;
    check("rr_no_rvalid", sie_rvalid, 1'b0);
    check("rr_owner", ep_owner, 4'b0000);
    check("rr_len0", len_out, 4'd0);
    len_sel = 2'd2;
    #1;
    check("rr_len2", len_out, 4'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rr_after_rvalid", sie_rvalid, 1'b0);
    check("rr_after_owner", ep_owner, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
